reg_ring_master: RTL

Initiator end of the UDP register ring. It accepts single register read and write requests from a core-side bus and launches each as a one-cycle request at the head of the ring. It then watches the ring tail for the same transaction to return, and hands the result back to the core with an ack. Exactly one transaction is outstanding at a time; unclaimed or lost transactions complete with an error.

---
 rtl/reg_ring_master_pkg.sv | 34 +++
 rtl/reg_ring_master_if.sv | 28 ++
 rtl/reg_ring_master_timeout.sv | 33 +++
 rtl/reg_ring_master.sv | 108 ++++++++++
 4 files changed

// File: rtl/reg_ring_master_pkg.sv
//----------------------------------------------------------------------------
// reg_ring_master_pkg : shared FSM encoding, error data constant and log2.
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

package reg_ring_master_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [`CPCI_NF2_DATA_WIDTH-1:0] c_err_data = 32'hDEAD_BEEF;

   // Ceiling log2, used to size counters from their terminal value.
   function automatic int unsigned log2(input int unsigned value);
      int unsigned bits;
      bits = 0;
      while ((64'd1 << bits) < 64'(value)) bits = bits + 1;
      return (bits == 0) ? 1 : bits;
   endfunction

endpackage

`default_nettype wire

// File: rtl/reg_ring_master_if.sv
//----------------------------------------------------------------------------
// reg_ring_master_if : core-side single-transaction register bus.
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface reg_ring_master_if;
   logic                            core_reg_req;
   logic                            core_reg_rd_wr_L;
   logic [`UDP_REG_ADDR_WIDTH-1:0]  core_reg_addr;
   logic [`CPCI_NF2_DATA_WIDTH-1:0] core_reg_wr_data;
   logic                            core_reg_ack;
   logic                            core_reg_err;
   logic [`CPCI_NF2_DATA_WIDTH-1:0] core_reg_rd_data;
   logic                            core_busy;

   modport master (
      output core_reg_req, core_reg_rd_wr_L, core_reg_addr, core_reg_wr_data,
      input  core_reg_ack, core_reg_err, core_reg_rd_data, core_busy
   );

   modport slave (
      input  core_reg_req, core_reg_rd_wr_L, core_reg_addr, core_reg_wr_data,
      output core_reg_ack, core_reg_err, core_reg_rd_data, core_busy
   );
endinterface

`default_nettype wire

// File: rtl/reg_ring_master_timeout.sv
//----------------------------------------------------------------------------
// reg_ring_timeout : saturating WAIT-cycle counter with clear/enable/expired.
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

module reg_ring_timeout
   import reg_ring_master_pkg::*;
#(
   parameter int unsigned TIMEOUT = 127
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int unsigned CNT_W = log2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_count <= '0;
      end else if (enable && !expired) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign expired = (r_count == CNT_W'(TIMEOUT));
endmodule

`default_nettype wire

// File: rtl/reg_ring_master.sv
//----------------------------------------------------------------------------
// reg_ring_master : register ring initiator, one outstanding transaction.
// Optional WAIT timeout enabled by REG_RING_MASTER_TIMEOUT_EN.   Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

module reg_ring_master
   import reg_ring_master_pkg::*;
#(
   parameter int unsigned UDP_REG_SRC_WIDTH = 2,
   parameter int unsigned SRC_ID            = 0,
   parameter int unsigned TIMEOUT           = 127
) (
   input  logic                            clk,
   input  logic                            reset,
   reg_ring_master_if.slave                core,
   output logic                            reg_req_out,
   output logic                            reg_ack_out,
   output logic                            reg_rd_wr_L_out,
   output logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
   output logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
   output logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_out,
   input  logic                            reg_req_in,
   input  logic                            reg_ack_in,
   input  logic                            reg_rd_wr_L_in,
   input  logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
   input  logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
   input  logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_in
);
   localparam logic [UDP_REG_SRC_WIDTH-1:0] c_src_id = UDP_REG_SRC_WIDTH'(SRC_ID);

   state_t r_state;
   logic   w_match;
   logic   w_expired;
   logic   w_unused_tail;

   assign w_match       = reg_req_in && (reg_src_in == c_src_id);
   assign w_unused_tail = ^{reg_rd_wr_L_in, reg_addr_in};

`ifdef REG_RING_MASTER_TIMEOUT_EN
   reg_ring_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (r_state == IDLE),
      .enable  (r_state == WAIT),
      .expired (w_expired)
   );
`else
   assign w_expired = 1'b0;
`endif

   assign core.core_busy = (r_state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state               <= IDLE;
         reg_req_out           <= 1'b0;
         reg_ack_out           <= 1'b0;
         reg_rd_wr_L_out       <= 1'b0;
         reg_addr_out          <= '0;
         reg_data_out          <= '0;
         reg_src_out           <= '0;
         core.core_reg_ack     <= 1'b0;
         core.core_reg_err     <= 1'b0;
         core.core_reg_rd_data <= '0;
      end else begin
         core.core_reg_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (core.core_reg_req) begin
                  reg_req_out     <= 1'b1;
                  reg_ack_out     <= 1'b0;
                  reg_rd_wr_L_out <= core.core_reg_rd_wr_L;
                  reg_addr_out    <= core.core_reg_addr;
                  reg_data_out    <= core.core_reg_rd_wr_L ? '0 : core.core_reg_wr_data;
                  reg_src_out     <= c_src_id;
                  r_state         <= WAIT;
               end
            end
            WAIT: begin
               reg_req_out <= 1'b0;
               // A return in the expiry cycle still wins over the timeout.
               if (w_match) begin
                  core.core_reg_ack     <= 1'b1;
                  core.core_reg_err     <= !reg_ack_in;
                  core.core_reg_rd_data <= reg_ack_in ? reg_data_in : c_err_data;
                  r_state               <= DONE;
               end else if (w_expired) begin
                  core.core_reg_ack     <= 1'b1;
                  core.core_reg_err     <= 1'b1;
                  core.core_reg_rd_data <= c_err_data;
                  r_state               <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end
endmodule

`default_nettype wire
